// File: rtl/modexp_io_sequencer.sv
// Word-serial operand loader and result collector for the ModExp core.
// Streams five WIDTH-bit operands LSW first, starts the computation, then reassembles res_out.
module modexp_io_sequencer #(
   parameter int WIDTH         = 4096,
   parameter int DATA_WIDTH    = 64,
   parameter int COMPLETE_CODE = 9,
   parameter int TIMEOUT       = 2**24
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  go,
   input  logic [WIDTH-1:0]      message,
   input  logic [WIDTH-1:0]      exponent,
   input  logic [WIDTH-1:0]      modulus,
   input  logic [WIDTH-1:0]      r_in,
   input  logic [WIDTH-1:0]      t_in,
   input  logic [DATA_WIDTH-1:0] nprime0_in,
   input  logic [4:0]            exp_state,
   input  logic [DATA_WIDTH-1:0] res_out,
   output logic [DATA_WIDTH-1:0] m_buf,
   output logic [DATA_WIDTH-1:0] e_buf,
   output logic [DATA_WIDTH-1:0] n_buf,
   output logic [DATA_WIDTH-1:0] r_buf,
   output logic [DATA_WIDTH-1:0] t_buf,
   output logic [DATA_WIDTH-1:0] nprime0,
   output logic                  startInput,
   output logic                  startCompute,
   output logic                  getResult,
   output logic [WIDTH-1:0]      result,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int NWORDS = WIDTH / DATA_WIDTH;
   localparam int IW     = $clog2(NWORDS);
   localparam int KW     = IW + 1;
   localparam int TW     = $clog2(TIMEOUT + 1);
   localparam logic [4:0]    DONE_CODE = 5'(COMPLETE_CODE);
   localparam logic [KW-1:0] LAST_K    = KW'(NWORDS - 1);
   localparam logic [TW-1:0] WD_LIMIT  = TW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_READ} state_t;

   state_t                  state_reg, state_next;
   logic [KW-1:0]           k_reg, k_next;
   logic [TW-1:0]           watchdog_reg, watchdog_next;
   logic                    skip_reg, skip_next;
   logic [DATA_WIDTH-1:0]   m_buf_next, e_buf_next, n_buf_next, r_buf_next, t_buf_next;
   logic [DATA_WIDTH-1:0]   nprime0_next;
   logic                    start_input_next, start_compute_next, get_result_next;
   logic [WIDTH-1:0]        result_next;
   logic                    busy_next, done_next, err_next;
   logic [IW-1:0]           word_idx;

   logic [DATA_WIDTH-1:0] m_words [NWORDS];
   logic [DATA_WIDTH-1:0] e_words [NWORDS];
   logic [DATA_WIDTH-1:0] n_words [NWORDS];
   logic [DATA_WIDTH-1:0] r_words [NWORDS];
   logic [DATA_WIDTH-1:0] t_words [NWORDS];

   genvar gi;
   generate
      for (gi = 0; gi < NWORDS; gi++) begin : g_words
         assign m_words[gi] = message[gi*DATA_WIDTH +: DATA_WIDTH];
         assign e_words[gi] = exponent[gi*DATA_WIDTH +: DATA_WIDTH];
         assign n_words[gi] = modulus[gi*DATA_WIDTH +: DATA_WIDTH];
         assign r_words[gi] = r_in[gi*DATA_WIDTH +: DATA_WIDTH];
         assign t_words[gi] = t_in[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Word presented on the next LOAD cycle; wraps on the last word but is unused then.
   assign word_idx = k_reg[IW-1:0] + IW'(1);

   always_comb begin
      state_next         = state_reg;
      k_next             = k_reg;
      watchdog_next      = watchdog_reg;
      skip_next          = skip_reg;
      m_buf_next         = m_buf;
      e_buf_next         = e_buf;
      n_buf_next         = n_buf;
      r_buf_next         = r_buf;
      t_buf_next         = t_buf;
      nprime0_next       = nprime0;
      start_input_next   = startInput;
      start_compute_next = startCompute;
      get_result_next    = getResult;
      result_next        = result;
      done_next          = 1'b0;
      err_next           = err;

      case (state_reg)
         S_IDLE: begin
            if (go) begin
               k_next           = '0;
               err_next         = 1'b0;
               nprime0_next     = nprime0_in;
               start_input_next = 1'b1;
               m_buf_next       = m_words[0];
               e_buf_next       = e_words[0];
               n_buf_next       = n_words[0];
               r_buf_next       = r_words[0];
               t_buf_next       = t_words[0];
               state_next       = S_LOAD;
            end
         end
         S_LOAD: begin
            k_next = k_reg + KW'(1);
            if (k_reg == LAST_K) begin
               start_input_next   = 1'b0;
               start_compute_next = 1'b1;
               watchdog_next      = '0;
               state_next         = S_WAIT;
            end else begin
               m_buf_next = m_words[word_idx];
               e_buf_next = e_words[word_idx];
               n_buf_next = n_words[word_idx];
               r_buf_next = r_words[word_idx];
               t_buf_next = t_words[word_idx];
            end
         end
         S_WAIT: begin
            watchdog_next = watchdog_reg + TW'(1);
            // Completion is checked first so it wins a tie with the watchdog.
            if (exp_state == DONE_CODE) begin
               get_result_next = 1'b1;
               k_next          = '0;
               skip_next       = 1'b1;
               state_next      = S_READ;
            end else if (watchdog_next == WD_LIMIT) begin
               err_next           = 1'b1;
               start_input_next   = 1'b0;
               start_compute_next = 1'b0;
               get_result_next    = 1'b0;
               state_next         = S_IDLE;
            end
         end
         S_READ: begin
            // ModExp needs one cycle after getResult rises before the first word is valid.
            if (skip_reg) begin
               skip_next = 1'b0;
            end else begin
               for (int i = 0; i < NWORDS; i++) begin
                  if (k_reg == KW'(i)) result_next[i*DATA_WIDTH +: DATA_WIDTH] = res_out;
               end
               k_next = k_reg + KW'(1);
               if (k_reg == LAST_K) begin
                  get_result_next    = 1'b0;
                  start_compute_next = 1'b0;
                  done_next          = 1'b1;
                  state_next         = S_IDLE;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase

      busy_next = (state_next != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= S_IDLE;
         k_reg        <= '0;
         watchdog_reg <= '0;
         skip_reg     <= 1'b0;
         m_buf        <= '0;
         e_buf        <= '0;
         n_buf        <= '0;
         r_buf        <= '0;
         t_buf        <= '0;
         nprime0      <= '0;
         startInput   <= 1'b0;
         startCompute <= 1'b0;
         getResult    <= 1'b0;
         result       <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         state_reg    <= state_next;
         k_reg        <= k_next;
         watchdog_reg <= watchdog_next;
         skip_reg     <= skip_next;
         m_buf        <= m_buf_next;
         e_buf        <= e_buf_next;
         n_buf        <= n_buf_next;
         r_buf        <= r_buf_next;
         t_buf        <= t_buf_next;
         nprime0      <= nprime0_next;
         startInput   <= start_input_next;
         startCompute <= start_compute_next;
         getResult    <= get_result_next;
         result       <= result_next;
         busy         <= busy_next;
         done         <= done_next;
         err          <= err_next;
      end
   end

endmodule

// File: tb/tb_modexp_io_sequencer.sv
// Bench for modexp_io_sequencer: behavioural ModExp model, result scoreboard,
// table of small exponentiations plus load-order, timeout, reset-abort and back-to-back runs.
module tb_modexp_io_sequencer;

   localparam int WIDTH   = 4096;
   localparam int DW      = 64;
   localparam int NW      = WIDTH / DW;
   localparam int TMO     = 100;
   localparam int DELAY   = 5;
   localparam logic [4:0] CODE = 5'd9;
   // LOAD + WAIT (model answers DELAY+2 cycles in) + READ + done cycle
   localparam int LAT     = NW + (DELAY + 2) + NW + 1 + 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             go;
   logic [WIDTH-1:0] message, exponent, modulus, r_in, t_in;
   logic [DW-1:0]    nprime0_in;
   logic [4:0]       exp_state;
   logic [DW-1:0]    res_out;
   logic [DW-1:0]    m_buf, e_buf, n_buf, r_buf, t_buf, nprime0;
   logic             startInput, startCompute, getResult;
   logic [WIDTH-1:0] result;
   logic             busy, done, err;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   logic [WIDTH-1:0] exp_q [$];

   modexp_io_sequencer #(
      .WIDTH(WIDTH), .DATA_WIDTH(DW), .COMPLETE_CODE(9), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .go(go),
      .message(message), .exponent(exponent), .modulus(modulus), .r_in(r_in), .t_in(t_in),
      .nprime0_in(nprime0_in), .exp_state(exp_state), .res_out(res_out),
      .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
      .nprime0(nprime0), .startInput(startInput), .startCompute(startCompute),
      .getResult(getResult), .result(result), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
      end
   endtask

   function automatic logic [WIDTH-1:0] mulmod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] n);
      logic [WIDTH:0] acc;
      logic [WIDTH:0] nn;
      nn  = {1'b0, n};
      acc = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         acc = acc << 1;
         if (acc >= nn) acc = acc - nn;
         if (b[i]) begin
            acc = acc + {1'b0, a};
            if (acc >= nn) acc = acc - nn;
         end
      end
      return acc[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] modexp(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                                               input logic [WIDTH-1:0] n);
      logic [WIDTH-1:0] acc;
      bit started;
      started = 1'b0;
      acc = '0;
      if (n != 1) acc[0] = 1'b1;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (started) acc = mulmod(acc, acc, n);
         if (e[i]) begin
            started = 1'b1;
            acc = mulmod(acc, m, n);
         end
      end
      return acc;
   endfunction

   function automatic logic [WIDTH-1:0] rand_wide();
      logic [WIDTH-1:0] v;
      for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [WIDTH-1:0] ext64(input logic [63:0] x);
      return {{(WIDTH-64){1'b0}}, x};
   endfunction

   function automatic bit outs_zero();
      return ({m_buf, e_buf, n_buf, r_buf, t_buf, nprime0} == '0) && (result == '0) &&
             !startInput && !startCompute && !getResult && !busy && !done && !err;
   endfunction

   // Behavioural ModExp: captures the streamed words, answers DELAY cycles into the compute.
   logic [WIDTH-1:0] m_cap, e_cap, n_cap, r_cap, t_cap, res_model;
   int  ld, rd, cnt;
   bit  hang = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_state <= '0;
         res_out   <= '0;
         ld        <= 0;
         rd        <= 0;
         cnt       <= 0;
      end else begin
         if (startInput) begin
            m_cap[ld*DW +: DW] <= m_buf;
            e_cap[ld*DW +: DW] <= e_buf;
            n_cap[ld*DW +: DW] <= n_buf;
            r_cap[ld*DW +: DW] <= r_buf;
            t_cap[ld*DW +: DW] <= t_buf;
            ld        <= ld + 1;
            exp_state <= '0;
         end else begin
            ld <= 0;
         end
         if (startCompute && !getResult && exp_state != CODE) begin
            if (cnt == DELAY && !hang) begin
               res_model <= modexp(m_cap, e_cap, n_cap);
               exp_state <= CODE;
            end else begin
               cnt <= cnt + 1;
            end
         end else if (!startCompute) begin
            cnt <= 0;
         end
         if (getResult) begin
            if (rd < NW) res_out <= res_model[rd*DW +: DW];
            rd <= rd + 1;
         end else begin
            rd <= 0;
         end
      end
   end

   // Scoreboard: every done pops one expected result.
   logic [WIDTH-1:0] exp_v;
   int wi;
   initial forever begin
      @(negedge clk);
      if (reset_n && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1'b0, 64'd1, 64'd0);
         end else begin
            exp_v = exp_q.pop_front();
            wi = 0;
            for (int i = NW - 1; i >= 0; i--)
               if (result[i*DW +: DW] != exp_v[i*DW +: DW]) wi = i;
            check($sformatf("result_word%0d", wi), result == exp_v, result[wi*DW +: DW], exp_v[wi*DW +: DW]);
            check("rt_capture", (r_cap == r_in) && (t_cap == t_in), r_cap[63:0], r_in[63:0]);
         end
      end
   end

   task automatic start_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                           input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] expv, input bit push);
      message    = m;
      exponent   = e;
      modulus    = n;
      r_in       = rand_wide();
      t_in       = rand_wide();
      nprime0_in = {$urandom, $urandom};
      if (push) exp_q.push_back(expv);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("go_accepted", busy && startInput && !err, {61'd0, busy, startInput, err}, 64'd6);
      check("nprime0", nprime0 == nprime0_in, nprime0, nprime0_in);
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!done && lat < 4000) begin
         @(negedge clk);
         lat++;
      end
      check("done_seen", done, {63'd0, done}, 64'd1);
   endtask

   typedef struct {
      logic [63:0] m;
      logic [63:0] e;
      logic [63:0] n;
      logic [63:0] expv;
   } vec_t;
   vec_t tbl [5];

   initial begin
      int lat, lat2, d0, seq_err, wc, cyc;
      logic [WIDTH-1:0] big_m, big_n, big_e, big_res, seq_m, seq_n, seq_res;

      tbl[0] = '{64'd8, 64'd13, 64'd77, 64'd50};
      tbl[1] = '{64'd3, 64'd5, 64'd7, 64'd5};
      tbl[2] = '{64'd2, 64'd10, 64'd1000, 64'd24};
      tbl[3] = '{64'd5, 64'd0, 64'd13, 64'd1};
      tbl[4] = '{64'd0, 64'd7, 64'd11, 64'd0};

      reset_n = 1'b0; go = 1'b0;
      message = '0; exponent = '0; modulus = '0; r_in = '0; t_in = '0; nprime0_in = '0;
      repeat (3) @(negedge clk);
      check("reset_state", outs_zero(), {53'd0, startInput, startCompute, getResult, busy, done, err, 5'd0}, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Table of small exponentiations
      for (int i = 0; i < 5; i++) begin
         d0 = done_cnt;
         start_op(ext64(tbl[i].m), ext64(tbl[i].e), ext64(tbl[i].n), ext64(tbl[i].expv), 1'b1);
         wait_done(lat);
         if (i == 0) check("latency", lat == LAT, 64'(lat), 64'(LAT));
         check("busy_cleared", !busy, {63'd0, busy}, 64'd0);
         repeat (3) @(negedge clk);
         check("single_done", done_cnt == d0 + 1, 64'(done_cnt - d0), 64'd1);
      end

      // Word order, with go pulses during LOAD word 10 and during WAIT
      for (int k = 0; k < NW; k++) seq_m[k*DW +: DW] = 64'(k + 1);
      seq_n = '1;
      seq_res = modexp(seq_m, ext64(64'd3), seq_n);
      d0 = done_cnt;
      seq_err = 0;
      start_op(seq_m, ext64(64'd3), seq_n, seq_res, 1'b1);
      for (int k = 0; k < NW; k++) begin
         if (m_buf != 64'(k + 1) || !startInput || startCompute) seq_err++;
         go = (k == 10);
         @(negedge clk);
      end
      go = 1'b0;
      check("m_buf_sequence", seq_err == 0, 64'(seq_err), 64'd0);
      check("compute_after_load", startCompute && !startInput, {62'd0, startCompute, startInput}, 64'd2);
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_done(lat);
      repeat (3) @(negedge clk);
      check("go_ignored_single_done", done_cnt == d0 + 1, 64'(done_cnt - d0), 64'd1);

      // Watchdog timeout
      hang = 1'b1;
      d0 = done_cnt;
      start_op(ext64(tbl[0].m), ext64(tbl[0].e), ext64(tbl[0].n), '0, 1'b0);
      wc = 0; cyc = 0;
      while (!err && cyc < 1000) begin
         if (startCompute) wc++;
         @(negedge clk);
         cyc++;
      end
      check("timeout_err", err, {63'd0, err}, 64'd1);
      check("timeout_wait_cycles", wc == TMO, 64'(wc), 64'(TMO));
      check("timeout_idle", !busy && !startCompute && !getResult && !startInput,
            {60'd0, busy, startCompute, getResult, startInput}, 64'd0);
      repeat (3) @(negedge clk);
      check("timeout_no_done", done_cnt == d0, 64'(done_cnt - d0), 64'd0);
      check("err_sticky", err, {63'd0, err}, 64'd1);
      hang = 1'b0;
      start_op(ext64(tbl[1].m), ext64(tbl[1].e), ext64(tbl[1].n), ext64(tbl[1].expv), 1'b1);
      wait_done(lat);

      // Reset while READ is capturing word 20
      @(negedge clk);
      start_op(ext64(tbl[0].m), ext64(tbl[0].e), ext64(tbl[0].n), ext64(tbl[0].expv), 1'b1);
      cyc = 0;
      while (!getResult && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("read_reached", getResult, {63'd0, getResult}, 64'd1);
      repeat (21) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("reset_abort", outs_zero(), {53'd0, startInput, startCompute, getResult, busy, done, err, 5'd0}, 64'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      start_op(ext64(tbl[0].m), ext64(tbl[0].e), ext64(tbl[0].n), ext64(tbl[0].expv), 1'b1);
      wait_done(lat);
      check("latency_after_reset", lat == LAT, 64'(lat), 64'(LAT));

      // Full-width key, twice back-to-back
      big_n = rand_wide();
      big_n[WIDTH-1] = 1'b1;
      big_n[0] = 1'b1;
      big_m = rand_wide();
      big_m[WIDTH-1] = 1'b0;
      big_e = ext64(64'hf3e7af);
      big_res = modexp(big_m, big_e, big_n);
      @(negedge clk);
      start_op(big_m, big_e, big_n, big_res, 1'b1);
      wait_done(lat);
      @(negedge clk);
      start_op(big_m, big_e, big_n, big_res, 1'b1);
      wait_done(lat2);
      check("b2b_latency_equal", lat == lat2, 64'(lat2), 64'(lat));
      check("b2b_latency", lat == LAT, 64'(lat), 64'(LAT));
      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got hang want finish");
      $fatal(1, "simulation time limit");
   end

endmodule
